// File: rtl/uart_rx_controller.sv
// 8N1 UART receiver with mid-bit sampling, a one-byte holding register and
// valid/ready hand-off. Reports framing errors and overruns as one-cycle pulses.
module uart_rx_controller #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       Clk,
    input  logic       Resetn,
    input  logic       Enable,
    input  logic       UART_RX_I,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [9:0] LP_HALF = 10'(CLKS_PER_BIT / 2 - 1);
    localparam logic [9:0] LP_FULL = 10'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t     r_state;
    logic [9:0] r_cnt;
    logic [2:0] r_idx;
    logic [7:0] r_shift;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_brk_wait;
    logic       w_rx_s;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= UART_RX_I;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_brk_wait <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // A load in the stop state below overrides this consume.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (!Enable) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_idx   <= '0;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        // After a framing error, the line must return high
                        // before a new start bit is considered.
                        if (r_brk_wait) begin
                            if (w_rx_s) begin
                                r_brk_wait <= 1'b0;
                            end
                        end else if (!w_rx_s) begin
                            r_state <= S_START;
                            busy    <= 1'b1;
                        end
                    end

                    S_START: begin
                        if (r_cnt == LP_HALF) begin
                            r_cnt <= '0;
                            r_idx <= '0;
                            if (!w_rx_s) begin
                                r_state <= S_DATA;
                            end else begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 10'd1;
                        end
                    end

                    S_DATA: begin
                        if (r_cnt == LP_FULL) begin
                            r_cnt   <= '0;
                            r_shift <= {w_rx_s, r_shift[7:1]};
                            if (r_idx == 3'd7) begin
                                r_idx   <= '0;
                                r_state <= S_STOP;
                            end else begin
                                r_idx <= r_idx + 3'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 10'd1;
                        end
                    end

                    S_STOP: begin
                        // Leave at mid stop bit so a back-to-back start edge is seen.
                        if (r_cnt == LP_FULL) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            if (w_rx_s) begin
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= r_shift;
                                    rx_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err  <= 1'b1;
                                r_brk_wait <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 10'd1;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx_controller.md
UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

Interface
REQ-001 Parameter: CLKS_PER_BIT, 868, Clk cycles per UART bit period; legal range 4..1023, even values only.
REQ-002 Port: Clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: Resetn  input  1  reset, asynchronous, active-low.
REQ-004 Port: Enable  input  1  receiver enable; low forces IDLE and aborts any frame in progress.
REQ-005 Port: UART_RX_I  input  1  serial line, asynchronous to Clk, idles high.
REQ-006 Port: rx_data  output  8  received byte, stable while rx_valid=1.
REQ-007 Port: rx_valid  output  1  holding register contains an unconsumed byte.
REQ-008 Port: rx_ready  input  1  consumer accepts rx_data on a Clk edge where rx_valid=1 and rx_ready=1.
REQ-009 Port: busy  output  1  high in every state except IDLE.
REQ-010 Port: frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 Port: overrun  output  1  one-cycle pulse: good byte dropped because holding register full.

Function
REQ-012 UART_RX_I SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions use synchronized value rx_s.
REQ-013 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1; no parity.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; one bit counter (10 bits) and one 3-bit data index.
REQ-015 IDLE: Enable=1 and rx_s=0 -> START, bit counter cleared to 0.
REQ-016 START: counter increments each cycle; at counter=CLKS_PER_BIT/2-1 sample rx_s: 0 -> DATA with counter=0, index=0; 1 -> IDLE (glitch rejected, no output activity).
REQ-017 DATA: at counter=CLKS_PER_BIT-1 sample rx_s into shift register (shift right, sample enters bit 7), counter=0, index+1; sample with index=7 -> STOP.
REQ-018 STOP: at counter=CLKS_PER_BIT-1 sample rx_s and return to IDLE the next cycle (mid stop bit), so back-to-back frames are received without loss.
REQ-019 Stop sample 1 and (rx_valid=0 or rx_ready=1 same cycle) -> rx_data loaded with shift register, rx_valid=1 on next edge.
REQ-020 Stop sample 1, rx_valid=1, rx_ready=0 -> byte discarded, rx_data unchanged, overrun pulses one cycle.
REQ-021 Stop sample 0 -> byte discarded, frame_err pulses one cycle, rx_valid/rx_data unchanged; IDLE then waits for rx_s=1 before accepting a new start (break condition not re-triggered).
REQ-022 rx_valid SHALL clear on the edge where rx_valid=1 and rx_ready=1 unless a new byte loads that same edge (REQ-019), in which case rx_valid stays 1.
REQ-023 Latency: rx_valid rises exactly 1 Clk after the stop-bit sample edge; stop sample occurs (1.5+8)*CLKS_PER_BIT + ... i.e. CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after start detection.
REQ-024 Enable deasserted mid-frame -> next edge IDLE, counters cleared, no rx_valid/frame_err/overrun for that frame; holding register unaffected.
REQ-025 Counters SHALL never wrap: every counter reaches its terminal value and clears.

Reset
REQ-026 Resetn low SHALL immediately force: state IDLE, counters 0, shift register 0, rx_data=0x00, rx_valid=0, busy=0, frame_err=0, overrun=0, synchronizer flops 1.
REQ-027 Reset mid-frame SHALL abandon the frame; after release, no output until a full new frame completes.

Verification (CLKS_PER_BIT=16)
REQ-028 Frame 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid high one cycle, frame_err=0, overrun=0.
REQ-029 Low glitch of 5 cycles on idle line -> START entered, rejected at sample, returns IDLE, no outputs.
REQ-030 Frame 0x3C with stop bit 0 -> frame_err one-cycle pulse, rx_valid stays 0; following frame 0x55 after line high received correctly.
REQ-031 Frames 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x11 held, overrun pulse on second stop sample; raise rx_ready -> rx_valid drops, 0x22 not present.
REQ-032 Resetn low at data bit 4 of frame 0xFF, released, then frame 0x81 -> only 0x81 delivered.
REQ-033 Enable=0 at data bit 2, re-enabled, then frame 0x7E -> only 0x7E delivered, busy low while disabled.
